// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the APB memory slave.
// APB_MEM_PSTRB_EN (optional) enables the APB4 byte-strobe port.
package apb_mem_pkg;

  typedef enum logic {IDLE, ACCESS} state_e;

  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

  // Index width over n entries; never zero so a single-entry array still has a usable index.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int off_w(input int bytes);
    return (bytes <= 1) ? 0 : $clog2(bytes);
  endfunction

endpackage

// File: rtl/apb_mem_if.sv
// APB bus bundle between a master and the memory slave.
// APB_MEM_PSTRB_EN adds the pstrb byte-lane strobes.
interface apb_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
`ifdef APB_MEM_PSTRB_EN
  logic [DATA_WIDTH/8-1:0] pstrb;
`endif
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
`ifdef APB_MEM_PSTRB_EN
    output pstrb,
`endif
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
`ifdef APB_MEM_PSTRB_EN
    input  pstrb,
`endif
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_mem_ram.sv
// Byte-lane word RAM with synchronous clear, per-lane write enables and a registered read port.
module apb_mem_ram
  import apb_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int IDX_W      = idx_w(DEPTH),
  parameter int BYTES      = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [BYTES-1:0]      wr_lanes,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  rd_zero,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] wr_word_d;
  logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;

  // Merge only the enabled lanes into the stored word so untouched bytes keep their value.
  always_comb begin
    wr_word_d = mem_q[wr_idx];
    for (int i = 0; i < BYTES; i++) begin
      if (wr_lanes[i]) wr_word_d[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = rd_zero ? '0 : mem_q[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      if (wr_en) mem_q[wr_idx] <= wr_word_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/apb_mem_slave.sv
// APB memory slave: FSM, address decode, wait-state counter and response registers.
// APB_MEM_PSTRB_EN enables byte strobes and the APB4 read-with-strobe error.
module apb_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 0
) (
  input  logic     pclk,
  input  logic     prst,
  apb_mem_if.slave bus
);

  localparam int BYTES   = DATA_WIDTH / 8;
  localparam int OFF_W   = off_w(BYTES);
  localparam int IDX_W   = idx_w(DEPTH);
  localparam int LIMIT_W = ADDR_WIDTH + 1;
  localparam logic [LIMIT_W-1:0] ADDR_LIMIT = LIMIT_W'(DEPTH * BYTES);
  localparam logic [CNT_W-1:0]   WAIT_INIT  = CNT_W'(WAIT_CYCLES);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BYTES-1:0]      strb_q, strb_d;
  logic                  err_q, err_d;

  logic [IDX_W-1:0] req_idx, rd_idx;
  logic [BYTES-1:0] req_strb;
  logic             req_err, strb_err, rd_en, rd_zero, wr_en;
  logic [DATA_WIDTH-1:0] rd_data;

  assign req_idx = bus.paddr[OFF_W +: IDX_W];

`ifdef APB_MEM_PSTRB_EN
  assign req_strb = bus.pstrb;
  assign strb_err = !bus.pwrite && (bus.pstrb != '0);
`else
  assign req_strb = '1;
  assign strb_err = 1'b0;
`endif

  // Out of range, misaligned, or a read carrying strobes.
  assign req_err = ({1'b0, bus.paddr} >= ADDR_LIMIT)
                || ((bus.paddr & ADDR_WIDTH'(BYTES - 1)) != '0)
                || strb_err;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    idx_d     = idx_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    err_d     = err_q;
    rd_en     = 1'b0;
    rd_idx    = idx_q;
    rd_zero   = err_q;
    wr_en     = 1'b0;
    case (state_q)
      IDLE: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        if (bus.psel && !bus.penable) begin
          state_d = ACCESS;
          cnt_d   = WAIT_INIT;
          idx_d   = req_idx;
          write_d = bus.pwrite;
          wdata_d = bus.pwdata;
          strb_d  = req_strb;
          err_d   = req_err;
          // Without wait states the response is produced on the SETUP edge from the live bus.
          if (WAIT_CYCLES == 0) begin
            pready_d  = 1'b1;
            pslverr_d = req_err;
            rd_en     = !bus.pwrite;
            rd_idx    = req_idx;
            rd_zero   = req_err;
          end
        end
      end
      ACCESS: begin
        if (!bus.psel) begin
          state_d   = IDLE;
          cnt_d     = '0;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end else if (pready_q) begin
          if (bus.penable) begin
            state_d   = IDLE;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            wr_en     = write_q && !err_q;
          end
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            pready_d  = 1'b1;
            pslverr_d = err_q;
            rd_en     = !write_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      err_q     <= err_d;
    end
  end

  apb_mem_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W),
    .BYTES     (BYTES)
  ) u_ram (
    .clk     (pclk),
    .rst     (prst),
    .wr_en   (wr_en),
    .wr_idx  (idx_q),
    .wr_lanes(strb_q),
    .wr_data (wdata_q),
    .rd_en   (rd_en),
    .rd_zero (rd_zero),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  assign bus.prdata  = rd_data;
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: three instances (WAIT_CYCLES 0, 3, 2) checked against a transaction-level model.
// Define APB_MEM_PSTRB_EN to exercise byte strobes.
module tb_apb_mem_slave;

  localparam int NU   = 3;
  localparam int SPAN = 256;
`ifdef APB_MEM_PSTRB_EN
  localparam bit PSTRB = 1'b1;
`else
  localparam bit PSTRB = 1'b0;
`endif

  function automatic int wait_of(input int u);
    return (u == 0) ? 0 : (u == 1) ? 3 : 2;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        psel [NU];
  logic        penable [NU];
  logic        pwrite [NU];
  logic [31:0] paddr [NU];
  logic [31:0] pwdata [NU];
  logic [3:0]  pstrb [NU];
  logic [31:0] prdata [NU];
  logic        pready [NU];
  logic        pslverr [NU];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < NU; g++) begin : gu
    apb_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    assign bus.psel    = psel[g];
    assign bus.penable = penable[g];
    assign bus.pwrite  = pwrite[g];
    assign bus.paddr   = paddr[g];
    assign bus.pwdata  = pwdata[g];
`ifdef APB_MEM_PSTRB_EN
    assign bus.pstrb   = pstrb[g];
`endif
    assign prdata[g]  = bus.prdata;
    assign pready[g]  = bus.pready;
    assign pslverr[g] = bus.pslverr;

    apb_mem_slave #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .DEPTH      (64),
      .WAIT_CYCLES(wait_of(g))
    ) dut (
      .pclk(clk),
      .prst(rst),
      .bus (bus)
    );
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Transaction-level model: byte memory, response latency of WAIT+1 cycles after SETUP.
  logic [7:0]  mdl [NU][SPAN];
  logic        busy [NU];
  int          age [NU];
  logic [31:0] t_addr [NU];
  logic [31:0] t_wdata [NU];
  logic [3:0]  t_strb [NU];
  logic        t_wr [NU];
  logic        t_err [NU];
  logic [31:0] last_rd [NU];
  logic        armed = 1'b0;
  logic        exp_rdy;
  logic [31:0] exp_rd;

  function automatic logic [31:0] model_word(input int u, input logic [31:0] a);
    int b;
    b = int'(a[7:0]);
    return {mdl[u][b+3], mdl[u][b+2], mdl[u][b+1], mdl[u][b]};
  endfunction

  function automatic logic model_err(input logic [31:0] a, input logic wr, input logic [3:0] strb);
    return (a >= 32'(SPAN)) || (a[1:0] != 2'b00) || (PSTRB && !wr && strb != 4'h0);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      armed = 1'b1;
      for (int u = 0; u < NU; u++) begin
        busy[u]    = 1'b0;
        age[u]     = 0;
        last_rd[u] = 32'h0;
        for (int a = 0; a < SPAN; a++) mdl[u][a] = 8'h00;
      end
    end else if (armed) begin
      for (int u = 0; u < NU; u++) begin
        exp_rdy = busy[u] && (age[u] == wait_of(u) + 1);
        exp_rd  = last_rd[u];
        if (exp_rdy && !t_wr[u]) begin
          exp_rd     = t_err[u] ? 32'h0 : model_word(u, t_addr[u]);
          last_rd[u] = exp_rd;
        end
        checkOutput($sformatf("u%0d.pready", u), {31'b0, pready[u]}, {31'b0, exp_rdy});
        checkOutput($sformatf("u%0d.pslverr", u), {31'b0, pslverr[u]}, {31'b0, exp_rdy && t_err[u]});
        checkOutput($sformatf("u%0d.prdata", u), prdata[u], exp_rd);
        if (busy[u]) begin
          if (!psel[u]) begin
            busy[u] = 1'b0;
          end else if (exp_rdy && penable[u]) begin
            if (t_wr[u] && !t_err[u]) begin
              for (int i = 0; i < 4; i++)
                if (t_strb[u][i]) mdl[u][int'(t_addr[u][7:0]) + i] = t_wdata[u][8*i +: 8];
            end
            busy[u] = 1'b0;
          end else begin
            age[u]++;
          end
        end else if (psel[u] && !penable[u]) begin
          busy[u]    = 1'b1;
          age[u]     = 1;
          t_addr[u]  = paddr[u];
          t_wr[u]    = pwrite[u];
          t_wdata[u] = pwdata[u];
          t_strb[u]  = PSTRB ? pstrb[u] : 4'hF;
          t_err[u]   = model_err(paddr[u], pwrite[u], pstrb[u]);
        end
      end
    end
  end

  // One APB transfer on unit u; entered and left just after a rising edge, bus idle on return.
  task automatic applyStimulus(input int u, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               output logic [31:0] rdata, output logic err, output int cycles);
    int n;
    psel[u]    = 1'b1;
    penable[u] = 1'b0;
    pwrite[u]  = wr;
    paddr[u]   = addr;
    pwdata[u]  = wdata;
    pstrb[u]   = strb;
    cycles     = 1;
    @(posedge clk); #1;
    penable[u] = 1'b1;
    cycles     = 2;
    n          = 0;
    @(negedge clk);
    while (pready[u] !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      cycles++;
      n++;
      @(negedge clk);
    end
    if (pready[u] !== 1'b1) checkOutput($sformatf("u%0d.timeout", u), {31'b0, pready[u]}, 32'h1);
    rdata = prdata[u];
    err   = pslverr[u];
    @(posedge clk); #1;
    psel[u]    = 1'b0;
    penable[u] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          cyc;
    for (int u = 0; u < NU; u++) begin
      psel[u] = 1'b0; penable[u] = 1'b0; pwrite[u] = 1'b0;
      paddr[u] = 32'h0; pwdata[u] = 32'h0; pstrb[u] = 4'h0;
    end

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int u = 0; u < NU; u++) begin
      checkOutput($sformatf("reset.u%0d.prdata", u), prdata[u], 32'h0);
      checkOutput($sformatf("reset.u%0d.pready", u), {31'b0, pready[u]}, 32'h0);
      checkOutput($sformatf("reset.u%0d.pslverr", u), {31'b0, pslverr[u]}, 32'h0);
    end
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, cyc);
    checkOutput("t1.read0", rd, 32'h0);

    applyStimulus(0, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF, rd, er, cyc);
    checkOutput("t2.wr_cycles", 32'(cyc), 32'd2);
    checkOutput("t2.wr_err", {31'b0, er}, 32'h0);
    applyStimulus(0, 1'b0, 32'h4, 32'h0, 4'h0, rd, er, cyc);
    checkOutput("t2.rd_data", rd, 32'hDEADBEEF);
    checkOutput("t2.rd_cycles", 32'(cyc), 32'd2);
    checkOutput("t2.rd_err", {31'b0, er}, 32'h0);

    applyStimulus(0, 1'b1, 32'h8, 32'h0BADF00D, 4'hF, rd, er, cyc);
    applyStimulus(0, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, cyc);
    checkOutput("b2b.rd_data", rd, 32'h0BADF00D);

    applyStimulus(1, 1'b1, 32'h8, 32'hA5A55A5A, 4'hF, rd, er, cyc);
    checkOutput("t3.wr_cycles", 32'(cyc), 32'd5);
    applyStimulus(1, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, cyc);
    checkOutput("t3.rd_cycles", 32'(cyc), 32'd5);
    checkOutput("t3.rd_data", rd, 32'hA5A55A5A);

    applyStimulus(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, er, cyc);
    applyStimulus(0, 1'b1, 32'h100, 32'h11111111, 4'hF, rd, er, cyc);
    checkOutput("t4.oor_err", {31'b0, er}, 32'h1);
    applyStimulus(0, 1'b1, 32'h2, 32'h22222222, 4'hF, rd, er, cyc);
    checkOutput("t4.misalign_err", {31'b0, er}, 32'h1);
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, cyc);
    checkOutput("t4.word0_kept", rd, 32'hCAFEF00D);
    checkOutput("t4.word0_err", {31'b0, er}, 32'h0);
    applyStimulus(0, 1'b0, 32'h102, 32'h0, 4'h0, rd, er, cyc);
    checkOutput("t4.rd_err", {31'b0, er}, 32'h1);
    checkOutput("t4.rd_err_data", rd, 32'h0);

    applyStimulus(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'hF, rd, er, cyc);
    applyStimulus(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, rd, er, cyc);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, cyc);
    checkOutput("t5.strb_data", rd, PSTRB ? 32'hFF22FF44 : 32'h11223344);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h3, rd, er, cyc);
    checkOutput("t5.rd_strb_err", {31'b0, er}, {31'b0, PSTRB});

    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
    paddr[2] = 32'hC; pwdata[2] = 32'h12345678; pstrb[2] = 4'hF;
    @(posedge clk); #1;
    penable[2] = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; psel[2] = 1'b0; penable[2] = 1'b0;
    checkOutput("t6.pready_after_rst", {31'b0, pready[2]}, 32'h0);
    applyStimulus(2, 1'b0, 32'hC, 32'h0, 4'h0, rd, er, cyc);
    checkOutput("t6.rd_data", rd, 32'h0);
    checkOutput("t6.rd_cycles", 32'(cyc), 32'd4);
    applyStimulus(0, 1'b0, 32'h4, 32'h0, 4'h0, rd, er, cyc);
    checkOutput("t6.u0_cleared", rd, 32'h0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
